// File: rtl/dvp_frame_gen.sv
// dvp_frame_gen: DVP camera-side transmitter. Emits byte-serial RGB565 test
// patterns with OV5640-style vsync/href timing, plus a completed-frame counter.
// Every output is registered from the next-state values, so each output lines
// up exactly with the FSM state it describes.
module dvp_frame_gen #(
   parameter int H_PIXEL  = 1024,
   parameter int V_PIXEL  = 768,
   parameter int H_BLANK  = 64,
   parameter int VS_LINES = 4,
   parameter int V_BACK   = 8,
   parameter int V_FRONT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_data,
   output logic [15:0] frame_cnt,
   output logic        frame_done,
   output logic        busy
);

   localparam int LT    = 2*H_PIXEL + H_BLANK;
   localparam int HW    = $clog2(LT);
   localparam int VW    = $clog2(VS_LINES + V_BACK + V_PIXEL + V_FRONT + 1);
   localparam int BAR_W = H_PIXEL / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(LT - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(2*H_PIXEL);
   localparam logic [VW-1:0] VS_LAST  = VW'(VS_LINES - 1);
   localparam logic [VW-1:0] VB_LAST  = VW'((V_BACK > 0) ? V_BACK - 1 : 0);
   localparam logic [VW-1:0] ACT_LAST = VW'(V_PIXEL - 1);
   localparam logic [VW-1:0] VF_LAST  = VW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

   generate
      if (H_PIXEL < 8 || (H_PIXEL % 8) != 0 || V_PIXEL < 1 || H_BLANK < 1 ||
          VS_LINES < 1 || V_BACK < 0 || V_FRONT < 0) begin : g_param_err
         $error("dvp_frame_gen: illegal timing parameters");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

   state_t          state, state_n;
   logic [HW-1:0]   hcnt, hcnt_n;     // clock within line
   logic [VW-1:0]   vcnt, vcnt_n;     // line within current state (= y in ACTIVE)
   logic [1:0]      pat, pat_n;       // pattern latched at frame start
   logic [15:0]     fcnt_n;
   logic            line_end, frame_end;
   logic [15:0]     x_n, y_n, pix;
   logic [2:0]      bar;
   logic            href_n, done_n;

   // Next-state: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT, zero-length states skipped
   always_comb begin
      state_n   = state;
      hcnt_n    = hcnt;
      vcnt_n    = vcnt;
      pat_n     = pat;
      fcnt_n    = frame_cnt;
      line_end  = (hcnt == H_LAST);
      frame_end = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_n = S_VSYNC;
               hcnt_n  = '0;
               vcnt_n  = '0;
               pat_n   = pattern_sel;
            end
         end
         default: begin
            hcnt_n = line_end ? '0 : hcnt + HW'(1);
            if (line_end) begin
               vcnt_n = vcnt + VW'(1);
               case (state)
                  S_VSYNC: if (vcnt == VS_LAST) begin
                     vcnt_n  = '0;
                     state_n = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                  end
                  S_VBACK: if (vcnt == VB_LAST) begin
                     vcnt_n  = '0;
                     state_n = S_ACTIVE;
                  end
                  S_ACTIVE: if (vcnt == ACT_LAST) begin
                     vcnt_n = '0;
                     if (V_FRONT > 0) state_n = S_VFRONT;
                     else             frame_end = 1'b1;
                  end
                  S_VFRONT: if (vcnt == VF_LAST) begin
                     vcnt_n    = '0;
                     frame_end = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      endcase
      // A finished frame either chains straight into the next VSYNC or parks in IDLE
      if (frame_end) begin
         fcnt_n = frame_cnt + 16'd1;
         if (en) begin
            state_n = S_VSYNC;
            pat_n   = pattern_sel;
         end else begin
            state_n = S_IDLE;
         end
      end
   end

   // Pixel value and strobes for the clock the next state describes
   always_comb begin
      x_n    = 16'(hcnt_n >> 1);
      y_n    = 16'(vcnt_n);
      bar    = 3'(x_n / 16'(BAR_W));
      href_n = (state_n == S_ACTIVE) && (hcnt_n < H_ACT);
      done_n = (hcnt_n == H_LAST) &&
               (((state_n == S_VFRONT) && (vcnt_n == VF_LAST)) ||
                ((V_FRONT == 0) && (state_n == S_ACTIVE) && (vcnt_n == ACT_LAST)));
      case (pat_n)
         2'd0: begin
            case (bar)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd1:    pix = x_n;
         2'd2:    pix = {y_n[7:0], x_n[7:0]};
         default: pix = {fcnt_n[7:0], x_n[7:0]};
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         hcnt       <= '0;
         vcnt       <= '0;
         pat        <= '0;
         frame_cnt  <= '0;
         cam_vsync  <= 1'b0;
         cam_href   <= 1'b0;
         cam_data   <= 8'h00;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         hcnt       <= hcnt_n;
         vcnt       <= vcnt_n;
         pat        <= pat_n;
         frame_cnt  <= fcnt_n;
         cam_vsync  <= (state_n == S_VSYNC);
         cam_href   <= href_n;
         cam_data   <= href_n ? (hcnt_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
         frame_done <= done_n;
         busy       <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb_dvp_frame_gen: scenario tasks for dvp_frame_gen, each cycle compared
// against a frame-time reference model (flat clock index within the frame).
module tb_dvp_frame_gen;

   localparam int HP = 8, VP = 4, HB = 4, VS = 1, VB = 1, VF = 1;
   localparam int LT    = 2*HP + HB;              // 20
   localparam int FRAME = (VS + VB + VP + VF) * LT; // 140

   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   localparam logic [7:0] BAR_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                             8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  pattern_sel;
   logic        cam_vsync, cam_href, frame_done, busy;
   logic [7:0]  cam_data;
   logic [15:0] frame_cnt;
   logic [27:0] obs;

   int n_err = 0, n_checks = 0, frames = 0;

   dvp_frame_gen #(.H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB),
                   .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .frame_cnt(frame_cnt), .frame_done(frame_done), .busy(busy));

   always #5 clk = ~clk;

   assign obs = {cam_vsync, cam_href, cam_data, frame_done, busy, frame_cnt};

   // Reference model: running flag, clock index within frame, latched pattern, frame count
   logic        m_run;
   int          m_t;
   logic [1:0]  m_pat;
   logic [15:0] m_fcnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0; m_t <= 0; m_pat <= 2'd0; m_fcnt <= 16'd0;
      end else if (!m_run) begin
         if (en) begin m_run <= 1'b1; m_t <= 0; m_pat <= pattern_sel; end
      end else if (m_t == FRAME - 1) begin
         m_fcnt <= m_fcnt + 16'd1;
         if (en) begin m_t <= 0; m_pat <= pattern_sel; end
         else m_run <= 1'b0;
      end else begin
         m_t <= m_t + 1;
      end
   end

   function automatic logic [27:0] model_out();
      int line, h, x, y;
      logic [15:0] pix;
      logic [7:0]  d;
      logic        vs, hr, dn;
      if (!m_run) return {12'h000, m_fcnt};
      line = m_t / LT;
      h    = m_t % LT;
      x    = h / 2;
      y    = line - VS - VB;
      vs   = (line < VS);
      hr   = (line >= VS + VB) && (line < VS + VB + VP) && (h < 2*HP);
      pix  = 16'h0000;
      if (hr) begin
         case (m_pat)
            2'd0:    pix = BARS[x / (HP/8)];
            2'd1:    pix = 16'(x);
            2'd2:    pix = {8'(y), 8'(x)};
            default: pix = {m_fcnt[7:0], 8'(x)};
         endcase
      end
      d  = hr ? (((h % 2) == 0) ? pix[15:8] : pix[7:0]) : 8'h00;
      dn = (m_t == FRAME - 1);
      return {vs, hr, d, dn, 1'b1, m_fcnt};
   endfunction

   task automatic test_reset();
      int vs_len = 0, vs_fall = -1, href_first = -1;
      rst_n = 1'b0; en = 1'b1; pattern_sel = 2'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 28'h0) begin n_err++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, 28'h0); end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL reset_frame cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 0) en = 1'b0;
         if (cam_vsync) vs_len++;
         else if (vs_len > 0 && vs_fall < 0) vs_fall = i;
         if (cam_href && href_first < 0) href_first = i;
      end
      n_checks++;
      if (vs_len != 20) begin n_err++; $display("FAIL vsync_len got=%0d exp=20", vs_len); end
      n_checks++;
      if (href_first - vs_fall != 20) begin n_err++; $display("FAIL href_delay got=%0d exp=20", href_first - vs_fall); end
      frames = 1;
   endtask

   task automatic test_bars();
      logic [7:0] bytes[$];
      int hi_q[$], lo_q[$];
      int pulses = 0, run = 0;
      logic prev = 1'b0;
      pattern_sel = 2'd0; en = 1'b1;
      for (int i = 0; i < 146; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL bars_frame cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 0) en = 1'b0;
         pattern_sel = 2'($urandom);
         if (cam_href) begin
            bytes.push_back(cam_data);
            if (!prev) begin pulses++; if (pulses > 1) lo_q.push_back(run); run = 0; end
            run++;
         end else begin
            if (prev) begin hi_q.push_back(run); run = 0; end
            run++;
         end
         prev = cam_href;
      end
      n_checks++;
      if (pulses != 4) begin n_err++; $display("FAIL bars_pulses got=%0d exp=4", pulses); end
      n_checks++;
      if (lo_q.size() != 3) begin n_err++; $display("FAIL bars_gaps got=%0d exp=3", lo_q.size()); end
      foreach (hi_q[k]) begin
         n_checks++;
         if (hi_q[k] != 16) begin n_err++; $display("FAIL bars_href_high line=%0d got=%0d exp=16", k, hi_q[k]); end
      end
      foreach (lo_q[k]) begin
         n_checks++;
         if (lo_q[k] != 4) begin n_err++; $display("FAIL bars_href_low gap=%0d got=%0d exp=4", k, lo_q[k]); end
      end
      n_checks++;
      if (bytes.size() != 64) begin n_err++; $display("FAIL bars_nbytes got=%0d exp=64", bytes.size()); end
      foreach (bytes[k]) begin
         n_checks++;
         if (bytes[k] !== BAR_BYTES[k % 16]) begin n_err++; $display("FAIL bars_byte idx=%0d got=%h exp=%h", k, bytes[k], BAR_BYTES[k % 16]); end
      end
      frames++;
   endtask

   task automatic test_grid();
      logic [7:0] bytes[$];
      int done_cnt = 0, done_idx = -1;
      logic [7:0] exp_b;
      pattern_sel = 2'd2; en = 1'b1;
      for (int i = 0; i < 143; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL grid_frame cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 0) en = 1'b0;
         if (cam_href) bytes.push_back(cam_data);
         if (frame_done) begin done_cnt++; done_idx = i; end
      end
      n_checks++;
      if (done_cnt != 1) begin n_err++; $display("FAIL grid_done_cnt got=%0d exp=1", done_cnt); end
      n_checks++;
      if (done_idx != FRAME - 1) begin n_err++; $display("FAIL grid_done_clock got=%0d exp=%0d", done_idx + 1, FRAME); end
      n_checks++;
      if (frame_cnt !== 16'(frames + 1)) begin n_err++; $display("FAIL grid_frame_cnt got=%0d exp=%0d", frame_cnt, frames + 1); end
      n_checks++;
      if (bytes.size() != 64) begin
         n_err++; $display("FAIL grid_nbytes got=%0d exp=64", bytes.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            exp_b = ((k % 2) == 0) ? 8'h03 : 8'(k / 2);
            n_checks++;
            if (bytes[48 + k] !== exp_b) begin n_err++; $display("FAIL grid_line3 idx=%0d got=%h exp=%h", k, bytes[48 + k], exp_b); end
         end
      end
      frames++;
   endtask

   task automatic test_en_drop();
      int pulses = 0, done_cnt = 0, vs_idle = 0;
      logic prev = 1'b0;
      pattern_sel = 2'($urandom); en = 1'b1;
      for (int i = 0; i < 180; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL drop_frame cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 50) en = 1'b0;
         if (cam_href && !prev) pulses++;
         prev = cam_href;
         if (frame_done) done_cnt++;
         if (i >= FRAME && cam_vsync) vs_idle++;
      end
      n_checks++;
      if (pulses != 4) begin n_err++; $display("FAIL drop_lines got=%0d exp=4", pulses); end
      n_checks++;
      if (done_cnt != 1) begin n_err++; $display("FAIL drop_done got=%0d exp=1", done_cnt); end
      n_checks++;
      if (vs_idle != 0) begin n_err++; $display("FAIL drop_idle_vsync got=%0d exp=0", vs_idle); end
      n_checks++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got=%b exp=0", busy); end
      frames++;
   endtask

   task automatic test_pattern_switch();
      logic [7:0] l1 [16];
      logic [7:0] l2 [2];
      logic       v140 = 1'b0;
      logic [7:0] exp_b;
      pattern_sel = 2'd1; en = 1'b1;
      for (int i = 0; i < 286; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL switch_frames cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 60) pattern_sel = 2'd3;
         if (i == 150) en = 1'b0;
         if (i >= 40 && i < 56) l1[i - 40] = cam_data;
         if (i == 180 || i == 181) l2[i - 180] = cam_data;
         if (i == FRAME) v140 = cam_vsync;
      end
      for (int k = 0; k < 16; k++) begin
         exp_b = ((k % 2) == 0) ? 8'h00 : 8'(k / 2);
         n_checks++;
         if (l1[k] !== exp_b) begin n_err++; $display("FAIL switch_ramp idx=%0d got=%h exp=%h", k, l1[k], exp_b); end
      end
      n_checks++;
      if (v140 !== 1'b1) begin n_err++; $display("FAIL switch_no_gap got=%b exp=1", v140); end
      n_checks++;
      if (l2[0] !== 8'(frames + 1)) begin n_err++; $display("FAIL switch_tag_hi got=%h exp=%h", l2[0], 8'(frames + 1)); end
      n_checks++;
      if (l2[1] !== 8'h00) begin n_err++; $display("FAIL switch_tag_lo got=%h exp=00", l2[1]); end
      frames += 2;
   endtask

   task automatic test_back_to_back();
      en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL random_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if ($urandom_range(0, 99) < 3) en = ~en;
         pattern_sel = 2'($urandom);
      end
      en = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (!busy) break;
      end
      n_checks++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL random_idle got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int r, vs_len = 0, done_idx = -1;
      r = 40 + 20 * $urandom_range(0, 3) + $urandom_range(0, 15);
      pattern_sel = 2'($urandom); en = 1'b1;
      for (int i = 0; i <= r; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL rmid_pre cyc=%0d got=%h exp=%h", i, obs, model_out()); end
      end
      n_checks++;
      if (cam_href !== 1'b1) begin n_err++; $display("FAIL rmid_in_active got=%b exp=1", cam_href); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 28'h0) begin n_err++; $display("FAIL rmid_async got=%h exp=%h", obs, 28'h0); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin n_err++; $display("FAIL rmid_restart cyc=%0d got=%h exp=%h", i, obs, model_out()); end
         if (i == 5) en = 1'b0;
         if (cam_vsync) vs_len++;
         if (frame_done) done_idx = i;
      end
      n_checks++;
      if (vs_len != 20) begin n_err++; $display("FAIL rmid_vsync_len got=%0d exp=20", vs_len); end
      n_checks++;
      if (done_idx != FRAME - 1) begin n_err++; $display("FAIL rmid_done_clock got=%0d exp=%0d", done_idx + 1, FRAME); end
      n_checks++;
      if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_frame_cnt got=%0d exp=1", frame_cnt); end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
      test_reset();
      test_bars();
      test_grid();
      test_en_drop();
      test_pattern_switch();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
